// File: rtl/pll_scan_reconfig_ctrl.sv
// PLL scan-chain reconfiguration sequencer: shifts a new image in while capturing the old
// chain, strobes configupdate, waits for scandone, then optionally resets the PLL and waits for lock.
module pll_scan_reconfig_ctrl #(
   parameter int unsigned SCAN_LEN      = 144,
   parameter int unsigned DONE_TIMEOUT  = 1024,
   parameter int unsigned ARESET_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned LOCK_STABLE   = 64
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                start,
   input  logic [SCAN_LEN-1:0] cfg_image,
   input  logic                skip_reset,
   output logic                busy,
   output logic                done,
   output logic [1:0]          error,
   output logic [SCAN_LEN-1:0] readback,
   output logic                pll_scanclkena,
   output logic                pll_scandata,
   input  logic                pll_scandataout,
   output logic                pll_configupdate,
   input  logic                pll_scandone,
   output logic                pll_areset,
   input  logic                pll_locked
);

   localparam int unsigned BIT_W  = $clog2(SCAN_LEN + 1);
   localparam int unsigned DONE_W = $clog2(DONE_TIMEOUT + 1);
   localparam int unsigned AR_W   = $clog2(ARESET_CYCLES + 1);
   localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

   localparam logic [1:0] ERR_OK        = 2'd0;
   localparam logic [1:0] ERR_SCANDONE  = 2'd1;
   localparam logic [1:0] ERR_LOCK      = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_UPDATE,
      S_WAIT_DONE,
      S_ARESET,
      S_WAIT_LOCK,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [SCAN_LEN-1:0] shreg_q;
   logic [SCAN_LEN-1:0] shreg_d;
   logic [SCAN_LEN-1:0] readback_q;
   logic [BIT_W-1:0]    bit_cnt_q;
   logic [DONE_W-1:0]   done_cnt_q;
   logic [AR_W-1:0]     ar_cnt_q;
   logic [LOCK_W-1:0]   lock_cnt_q;
   logic [STAB_W-1:0]   stab_cnt_q;
   logic [1:0]          lock_sync_q;
   logic [1:0]          error_q;
   logic                skip_q;
   logic                busy_q;
   logic                done_q;
   logic                configupdate_q;
   logic                areset_q;
   logic                locked_s;

   // Old chain bits enter at the LSB while the new image leaves from the MSB.
   assign shreg_d  = {shreg_q[SCAN_LEN-2:0], pll_scandataout};
   assign locked_s = lock_sync_q[1];

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q        <= S_IDLE;
         shreg_q        <= '0;
         readback_q     <= '0;
         bit_cnt_q      <= '0;
         done_cnt_q     <= '0;
         ar_cnt_q       <= '0;
         lock_cnt_q     <= '0;
         stab_cnt_q     <= '0;
         lock_sync_q    <= '0;
         error_q        <= ERR_OK;
         skip_q         <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         configupdate_q <= 1'b0;
         areset_q       <= 1'b0;
      end else begin
         lock_sync_q    <= {lock_sync_q[0], pll_locked};
         done_q         <= 1'b0;
         configupdate_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  shreg_q   <= cfg_image;
                  skip_q    <= skip_reset;
                  error_q   <= ERR_OK;
                  busy_q    <= 1'b1;
                  bit_cnt_q <= '0;
                  state_q   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               shreg_q <= shreg_d;
               if (bit_cnt_q == BIT_W'(SCAN_LEN - 1)) begin
                  readback_q     <= shreg_d;
                  configupdate_q <= 1'b1;
                  state_q        <= S_UPDATE;
               end else begin
                  bit_cnt_q <= bit_cnt_q + BIT_W'(1);
               end
            end
            S_UPDATE: begin
               done_cnt_q <= '0;
               state_q    <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               // scandone takes priority over a timeout in the same cycle
               if (pll_scandone) begin
                  if (skip_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     areset_q <= 1'b1;
                     ar_cnt_q <= '0;
                     state_q  <= S_ARESET;
                  end
               end else if (done_cnt_q == DONE_W'(DONE_TIMEOUT - 1)) begin
                  error_q <= ERR_SCANDONE;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  done_cnt_q <= done_cnt_q + DONE_W'(1);
               end
            end
            S_ARESET: begin
               if (ar_cnt_q == AR_W'(ARESET_CYCLES - 1)) begin
                  areset_q   <= 1'b0;
                  lock_cnt_q <= '0;
                  stab_cnt_q <= '0;
                  state_q    <= S_WAIT_LOCK;
               end else begin
                  ar_cnt_q <= ar_cnt_q + AR_W'(1);
               end
            end
            S_WAIT_LOCK: begin
               // a stable run completing on the timeout cycle still counts as locked
               if (locked_s && (stab_cnt_q == STAB_W'(LOCK_STABLE - 1))) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (lock_cnt_q == LOCK_W'(LOCK_TIMEOUT - 1)) begin
                  error_q <= ERR_LOCK;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                  stab_cnt_q <= locked_s ? (stab_cnt_q + STAB_W'(1)) : '0;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign readback         = readback_q;
   assign pll_scanclkena   = (state_q == S_SHIFT);
   assign pll_scandata     = pll_scanclkena & shreg_q[SCAN_LEN-1];
   assign pll_configupdate = configupdate_q;
   assign pll_areset       = areset_q;

endmodule

// File: doc/pll_scan_reconfig_ctrl.md
Name: pll_scan_reconfig_ctrl

Overview:
Sequences run-time reconfiguration of the system PLL through its scan-chain conduit (scanclkena, scandata, scandataout, configupdate, scandone, areset, locked).
- On a start request it shifts a full scan image into the PLL and captures the old chain contents.
- It then pulses configupdate, waits for scandone, optionally resets the PLL and waits for stable lock.
- Sits beside the Qsys system in the top level. The PLL scanclk is tied externally to the same clk_clk.

Parameters:
- SCAN_LEN, 144, scan-chain length in bits.
- DONE_TIMEOUT, 1024, max cycles to wait for scandone after configupdate.
- ARESET_CYCLES, 16, cycles pll_areset is held high.
- LOCK_TIMEOUT, 65536, max cycles to wait for stable lock.
- LOCK_STABLE, 64, consecutive synchronised-locked cycles required.

Ports:
- clk_clk  in  1  system clock; also the PLL scan clock.
- reset_reset_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; accepted only in IDLE.
- cfg_image  in  SCAN_LEN  new scan image; bit SCAN_LEN-1 is shifted first.
- skip_reset  in  1  when 1, omit the areset/lock phase; sampled with start.
- busy  out  1  high from the cycle after acceptance until the DONE cycle inclusive.
- done  out  1  single-cycle completion pulse.
- error  out  2  result code: 0 ok, 1 scandone timeout, 2 lock timeout.
- readback  out  SCAN_LEN  previous chain contents captured during shift.
- pll_scanclkena  out  1  scan clock enable.
- pll_scandata  out  1  serial scan data.
- pll_scandataout  in  1  serial data out of the chain.
- pll_configupdate  out  1  update strobe.
- pll_scandone  in  1  update complete, clk_clk domain.
- pll_areset  out  1  PLL reset.
- pll_locked  in  1  PLL lock, asynchronous.

Behaviour:
- One clock, clk_clk. Reset is synchronous, active-low on reset_reset_n.
- While reset_reset_n=0, all outputs are 0 (busy, done, error, readback, scanclkena, scandata, configupdate, areset). FSM goes to IDLE and all counters and the shift register clear. A reset mid-operation aborts at once with no done pulse.
- pll_locked passes through a 2-flop synchroniser (locked_s); downstream logic sees 2 cycles of latency. pll_scandone is used directly.
- FSM: IDLE, SHIFT, UPDATE, WAIT_DONE, ARESET, WAIT_LOCK, DONE.
- IDLE:
  - start=1 at cycle T loads shreg<=cfg_image, latches skip_reset, sets error<=0, goes to SHIFT.
  - busy=1 from T+1.
- SHIFT:
  - Lasts exactly SCAN_LEN cycles (T+1 .. T+SCAN_LEN).
  - pll_scanclkena=1 and pll_scandata=shreg[MSB] combinationally from the register.
  - Each cycle: shreg<={shreg[SCAN_LEN-2:0], pll_scandataout}.
  - On the last cycle, bit counter=SCAN_LEN-1. Next state is UPDATE, and readback takes the final shifted value, i.e. the captured old chain.
- UPDATE: pll_configupdate=1 for exactly one cycle (T+SCAN_LEN+1); scanclkena=0. Next state WAIT_DONE.
- WAIT_DONE:
  - Counter starts at 0.
  - pll_scandone=1 goes to ARESET, or to DONE if skip_reset was latched.
  - If the counter reaches DONE_TIMEOUT-1 without scandone, error<=1 and go to DONE.
  - Scandone and timeout in the same cycle: scandone wins.
- ARESET: pll_areset=1 for ARESET_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK:
  - A stable counter increments while locked_s=1 and clears to 0 when locked_s=0.
  - Reaching LOCK_STABLE goes to DONE with error unchanged (0).
  - If the timeout counter reaches LOCK_TIMEOUT-1 first, error<=2 and go to DONE.
  - Stable and timeout reached in the same cycle: stable wins.
- DONE: done=1 and busy=1 for one cycle, then IDLE; busy=0 the following cycle.
- start is ignored whenever the FSM is not IDLE, including the DONE cycle. cfg_image and skip_reset are don't-care outside the accepting cycle.
- error and readback hold until the next accepted start; error is cleared at acceptance, readback at end of the next SHIFT.
- Counter widths are sized with $clog2 of their parameter (+1). There is no wrap-around: every counter stops at its terminal value.

Test Plan:
- Directed, and every scenario asserts exact cycle counts. For directed runs override SCAN_LEN=8, DONE_TIMEOUT=16, ARESET_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE=4.
- Basic shift: cfg_image=8'hA5, skip_reset=1, PLL model returns old chain 8'h3C, scandone asserted 3 cycles after configupdate.
  -> scandata sequence 1,0,1,0,0,1,0,1 over 8 cycles with scanclkena high.
  -> configupdate high one cycle at T+9; readback=8'h3C.
  -> done at T+13, error=0.
- Full sequence: skip_reset=0, locked model drops at areset and returns 10 cycles after areset falls.
  -> areset high exactly 4 cycles.
  -> done 2 (sync) + 4 (stable) cycles after locked rises; error=0.
- Scandone timeout: scandone held 0.
  -> error=1 and done exactly 16 cycles after entering WAIT_DONE; areset never asserted.
- Lock glitch/timeout:
  - locked toggles 1,1,1,0 repeatedly -> stable counter never reaches 4; error=2 after 64 WAIT_LOCK cycles.
  - Separate run with locked rising on the timeout cycle -> stable wins only if its count completes that cycle.
- Start while busy, and reset mid-SHIFT:
  - Second start during SHIFT and during DONE is ignored; readback reflects the first image only.
  - reset_reset_n=0 at shift bit 5 -> next cycle all outputs 0, no done.
  - A fresh start then completes normally.
